sipo_rx_ctrl: RTL and testbench

Frame controller for the serial-in/parallel-out shift datapath. It waits for a start strobe, then clocks exactly WIDTH serial bits into an internal shift register. It presents the assembled word on a registered parallel output with a valid/ready handshake. The block sits between a serial line source and any parallel consumer, and it reports overrun when the consumer falls behind.

---
 rtl/sipo_rx_ctrl_if.sv | 32 +++
 rtl/sipo_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_ctrl_if.sv
// Handshake bundle for sipo_rx_ctrl: serial start/in, parallel q with valid/ready, status flags.
// parity_err is present only when SIPO_RX_CTRL_PARITY_EN is defined.
interface sipo_rx_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             in;
    logic             busy;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             ready;
    logic             overrun;
`ifdef SIPO_RX_CTRL_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output start, in, ready,
        input  busy, q, valid, overrun
`ifdef SIPO_RX_CTRL_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  start, in, ready,
        output busy, q, valid, overrun
`ifdef SIPO_RX_CTRL_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Serial-in frame receiver with registered parallel output; SIPO_RX_CTRL_PARITY_EN adds an even-parity bit.
// Latency: WIDTH cycles from the start edge to valid (WIDTH+1 with parity).
// Backpressure: a word completing while the previous one is untaken is dropped and sets sticky overrun.
module sipo_rx_ctrl #(
    parameter int WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    sipo_rx_ctrl_if.slave rx
);
    localparam int CW = $clog2(WIDTH);
`ifdef SIPO_RX_CTRL_PARITY_EN
    localparam int SW = WIDTH;
`else
    localparam int SW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             shift_en;
    logic             complete;
    logic             take;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    shreg;
    logic [WIDTH-1:0] shift_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_r;
    logic             valid_r;
    logic             busy_r;
    logic             overrun_r;

    // Without parity the last data bit is taken straight from the line, so
    // the register only ever needs to hold the first WIDTH-1 bits.
`ifdef SIPO_RX_CTRL_PARITY_EN
    logic             parity_err_r;
    assign shift_nxt = {shreg[WIDTH-2:0], rx.in};
    assign word      = shreg;
`else
    assign shift_nxt = {shreg, rx.in};
    assign word      = shift_nxt;
`endif

    assign take = !valid_r || rx.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (rx.start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_CTRL_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
                    complete  = 1'b1;
`endif
                end
            end
            PARITY: begin
                state_nxt = IDLE;
                complete  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            shreg     <= '0;
            q_r       <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
`ifdef SIPO_RX_CTRL_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            busy_r <= (state_nxt != IDLE);
            if (state == IDLE) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt <= cnt + 1'b1;
            end
            if (shift_en) begin
                shreg <= shift_nxt[SW-1:0];
            end
            if (complete) begin
                if (take) begin
                    q_r     <= word;
                    valid_r <= 1'b1;
`ifdef SIPO_RX_CTRL_PARITY_EN
                    parity_err_r <= (^word) ^ rx.in;
`endif
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (valid_r && rx.ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign rx.busy    = busy_r;
    assign rx.q       = q_r;
    assign rx.valid   = valid_r;
    assign rx.overrun = overrun_r;
`ifdef SIPO_RX_CTRL_PARITY_EN
    assign rx.parity_err = parity_err_r;
`endif
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Randomized scoreboard bench for sipo_rx_ctrl; builds with or without SIPO_RX_CTRL_PARITY_EN.
module tb_sipo_rx_ctrl;
    localparam int WIDTH = 4;
`ifdef SIPO_RX_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();
    sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    exp_t sbq[$];
    bit   m_valid = 1'b0;
    bit   m_over  = 1'b0;
    bit   m_busy  = 1'b0;
    int   rdy_mode = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Apply inputs, take one clock edge, then advance the transaction-level model.
    task automatic drive_edge(input logic st, input logic b, input bit done,
                              input logic [WIDTH-1:0] w, input logic pe, input bit busy_after);
        bus.start = st;
        bus.in    = b;
        case (rdy_mode)
            0:       bus.ready = 1'b1;
            1:       bus.ready = 1'b0;
            2:       bus.ready = ($urandom_range(0, 2) != 0);
            default: bus.ready = done;
        endcase
        @(posedge clk);
        if (done) begin
            if (!m_valid || bus.ready) begin
                sbq.push_back('{word: w, perr: pe});
                m_valid = 1'b1;
            end else begin
                m_over = 1'b1;
            end
        end else if (m_valid && bus.ready) begin
            m_valid = 1'b0;
        end
        m_busy = busy_after;
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic p, input bit noisy);
        logic pe;
        pe = PAR ? ((^w) ^ p) : 1'b0;
        drive_edge(1'b1, 1'($urandom_range(0, 1)), 1'b0, w, pe, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            drive_edge(noisy ? 1'($urandom_range(0, 1)) : 1'b0, w[WIDTH-1-i],
                       (i == WIDTH - 1) && !PAR, w, pe, !((i == WIDTH - 1) && !PAR));
        end
        if (PAR) begin
            drive_edge(noisy ? 1'($urandom_range(0, 1)) : 1'b0, p, 1'b1, w, pe, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_edge(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_q"}, 32'(bus.q), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
`ifdef SIPO_RX_CTRL_PARITY_EN
        chk({tag, "_parity_err"}, 32'(bus.parity_err), 32'd0);
`endif
    endtask

    // Monitor: status every cycle; pops and compares the word on each transfer.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 32'(bus.valid), 32'(m_valid));
            chk("overrun", 32'(bus.overrun), 32'(m_over));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            if (bus.valid && bus.ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_empty actual q=%0h required no word", bus.q);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("q", 32'(bus.q), 32'(e.word));
`ifdef SIPO_RX_CTRL_PARITY_EN
                    chk("parity_err", 32'(bus.parity_err), 32'(e.perr));
`endif
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.in    = 1'b0;
        bus.ready = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        rdy_mode = 0;
        send_frame(4'b1011, 1'b1, 1'b0);
        idle(2);
        rdy_mode = 1;
        send_frame(4'b1011, 1'b1, 1'b1);
        rdy_mode = 3;
        send_frame(4'b0101, 1'b0, 1'b0);
        rdy_mode = 0;
        idle(2);
        rdy_mode = 1;
        send_frame(4'b1011, 1'b1, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b1);
        idle(2);
        rdy_mode = 0;
        idle(3);

        // Reset after E2 of a frame: everything returns to zero at once.
        drive_edge(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        drive_edge(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        drive_edge(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        sbq.delete();
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_busy  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(4'b1100, 1'b0, 1'b0);
        idle(1);

        send_frame(4'b1011, 1'b1, 1'b0);
        send_frame(4'b1011, 1'b0, 1'b0);
        idle(2);

        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send_frame(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'($urandom_range(0, 1)), 1'b1);
            idle($urandom_range(0, 3));
        end
        rdy_mode = 0;
        idle(4);
        chk("drain_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
